// File: rtl/dma_read_engine.sv
// Read-side DMA engine. When started, it requests a contiguous range of cache
// lines from the shell in 1/2/4-line bursts. Responses are buffered in a
// prefetch FIFO and streamed in order to a consumer that can apply
// almost-full backpressure. A credit counter bounds the lines requested
// plus the lines buffered, so the FIFO can never overflow.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           start pulse, accepted only while idle
//   async           early-done mode: done pulses when the last request issues
//   regs0           number of lines to read
//   addr            first cache-line address
//   idle, active    status flags
//   done            one-cycle completion pulse
//   tx_re           read request valid, with tx_raddr and tx_rlength
//                   (tx_rlength: 00 = 1 line, 01 = 2 lines, 11 = 4 lines)
//   tx_ralmostfull  shell request backpressure
//   rx_rvalid       response line valid, with rx_rdata (in request order)
//   out_rvalid      line valid to the consumer, with out_rdata
//   out_almostfull  consumer backpressure
module dma_read_engine #(
  parameter int unsigned LOG2_FIFO_DEPTH = 9,
  parameter int unsigned CLADDR_WIDTH    = 42,
  parameter int unsigned CLDATA_WIDTH    = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    async,
  input  logic [31:0]             regs0,
  input  logic [CLADDR_WIDTH-1:0] addr,
  output logic                    idle,
  output logic                    active,
  output logic                    done,
  output logic                    tx_re,
  output logic [CLADDR_WIDTH-1:0] tx_raddr,
  output logic [1:0]              tx_rlength,
  input  logic                    tx_ralmostfull,
  input  logic                    rx_rvalid,
  input  logic [CLDATA_WIDTH-1:0] rx_rdata,
  output logic                    out_rvalid,
  output logic [CLDATA_WIDTH-1:0] out_rdata,
  input  logic                    out_almostfull
);

  localparam int unsigned DEPTH = 2 ** LOG2_FIFO_DEPTH;
  localparam int unsigned CNT_W = LOG2_FIFO_DEPTH + 1;
  localparam int unsigned SUM_W = LOG2_FIFO_DEPTH + 2;
  localparam int unsigned PTR_W = LOG2_FIFO_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [CLADDR_WIDTH-1:0] req_addr;
  logic [31:0]             req_left;
  logic [31:0]             rx_left;
  logic                    async_mode;
  logic                    done_sent;
  logic [CNT_W-1:0]        reserved;

  logic [CLDATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;

  logic [2:0]              burst_len;
  logic [1:0]              burst_code;
  logic                    credit_ok;
  logic                    issue;
  logic                    last_issue;
  logic                    push;
  logic                    pop;

  // Next-state, burst selection and FIFO handshake decisions.
  always_comb begin
    state_next = state;
    burst_len  = 3'd1;
    burst_code = 2'b00;

    if ((req_addr[1:0] == 2'b00) && (req_left >= 32'd4)) begin
      burst_len  = 3'd4;
      burst_code = 2'b11;
    end else if ((req_addr[0] == 1'b0) && (req_left >= 32'd2)) begin
      burst_len  = 3'd2;
      burst_code = 2'b01;
    end

    // Credit covers lines in flight from the shell plus lines sitting in the FIFO.
    credit_ok  = (SUM_W'(reserved) + SUM_W'(burst_len)) <= SUM_W'(DEPTH);
    issue      = (state == S_REQUEST) && !tx_ralmostfull && credit_ok;
    last_issue = issue && (req_left == 32'(burst_len));
    push       = rx_rvalid && ((state == S_REQUEST) || (state == S_DRAIN));
    pop        = (fifo_count != '0) && !out_almostfull;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (regs0 == 32'd0) ? S_DONE : S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (last_issue) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Empty FIFO with nothing left to receive: the last pop has already
        // been presented on out_*.
        if ((rx_left == 32'd0) && (fifo_count == '0)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      req_left   <= '0;
      rx_left    <= '0;
      async_mode <= 1'b0;
      done_sent  <= 1'b0;
      reserved   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      idle       <= 1'b1;
      active     <= 1'b0;
      done       <= 1'b0;
      tx_re      <= 1'b0;
      tx_raddr   <= '0;
      tx_rlength <= 2'b00;
      out_rvalid <= 1'b0;
      out_rdata  <= '0;
    end else begin
      state <= state_next;

      if ((state == S_IDLE) && start) begin
        req_addr   <= addr;
        req_left   <= regs0;
        rx_left    <= regs0;
        async_mode <= async;
        done_sent  <= 1'b0;
      end else if (issue) begin
        req_addr <= req_addr + CLADDR_WIDTH'(burst_len);
        req_left <= req_left - 32'(burst_len);
      end

      if (push) begin
        rx_left <= rx_left - 32'd1;
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_rdata <= mem[rd_ptr];
      end
      out_rvalid <= pop;

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      reserved <= reserved + (issue ? CNT_W'(burst_len) : CNT_W'(0))
                           - (pop ? CNT_W'(1) : CNT_W'(0));

      tx_re <= issue;
      if (issue) begin
        tx_raddr   <= req_addr;
        tx_rlength <= burst_code;
      end

      if (last_issue && async_mode) begin
        done_sent <= 1'b1;
      end
      done <= (last_issue && async_mode) || ((state == S_DONE) && !done_sent);

      // idle rises only once the DONE cycle is over, so it follows the done pulse.
      idle   <= (state == S_IDLE) && (state_next == S_IDLE);
      active <= (state_next == S_REQUEST) || (state_next == S_DRAIN);
    end
  end

  // Prefetch FIFO storage; contents need no reset, the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_rdata;
    end
  end

endmodule

// File: tb/tb_dma_read_engine.sv
module tb_dma_read_engine;

  localparam int unsigned LOG2  = 3;
  localparam int unsigned DEPTH = 2 ** LOG2;
  localparam int unsigned AW    = 42;
  localparam int unsigned DW    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          async = 1'b0;
  logic [31:0]   regs0 = '0;
  logic [AW-1:0] addr = '0;
  logic          idle, active, done, tx_re;
  logic [AW-1:0] tx_raddr;
  logic [1:0]    tx_rlength;
  logic          tx_ralmostfull = 1'b0;
  logic          rx_rvalid = 1'b0;
  logic [DW-1:0] rx_rdata = '0;
  logic          out_rvalid;
  logic [DW-1:0] out_rdata;
  logic          out_almostfull = 1'b0;

  dma_read_engine #(.LOG2_FIFO_DEPTH(LOG2), .CLADDR_WIDTH(AW), .CLDATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .async(async), .regs0(regs0), .addr(addr),
    .idle(idle), .active(active), .done(done), .tx_re(tx_re), .tx_raddr(tx_raddr),
    .tx_rlength(tx_rlength), .tx_ralmostfull(tx_ralmostfull), .rx_rvalid(rx_rvalid),
    .rx_rdata(rx_rdata), .out_rvalid(out_rvalid), .out_rdata(out_rdata),
    .out_almostfull(out_almostfull)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  // Environment knobs.
  int unsigned rsp_delay = 0;
  int unsigned rx_rate   = 100;
  int unsigned oaf_rate  = 0;
  int unsigned tx_rate   = 0;
  bit          oaf_force = 1'b0;

  typedef struct { logic [AW-1:0] a; logic [1:0] code; int unsigned c; } req_t;
  typedef struct { logic [AW-1:0] a; int unsigned ready; } pend_t;

  req_t          req_q[$];
  pend_t         pend[$];
  logic [DW-1:0] out_q[$];
  int unsigned   out_cyc[$];
  bit            out_act[$];
  int unsigned   done_q[$];
  int            req_lines, out_lines, max_outst, stall_lines;
  int unsigned   idle_cyc;

  logic [AW-1:0] exp_addr[$];
  logic [1:0]    exp_code[$];
  logic [DW-1:0] exp_data[$];

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return {lo * 32'h9E37_79B1, lo ^ 32'h5A5A_1234};
  endfunction

  // Reference: walk the range with the burst rules, list requests and expected lines.
  function automatic void build_model(input int unsigned n, input logic [AW-1:0] a);
    logic [AW-1:0] cur;
    int unsigned   left, len;
    exp_addr.delete(); exp_code.delete(); exp_data.delete();
    cur = a; left = n;
    while (left > 0) begin
      if ((cur % 4 == 0) && left >= 4)      len = 4;
      else if ((cur % 2 == 0) && left >= 2) len = 2;
      else                                  len = 1;
      exp_addr.push_back(cur);
      exp_code.push_back(len == 4 ? 2'b11 : (len == 2 ? 2'b01 : 2'b00));
      cur  = cur + AW'(len);
      left = left - len;
    end
    for (int i = 0; i < int'(n); i++) exp_data.push_back(line_data(a + AW'(i)));
  endfunction

  // Monitor: log requests, outputs and done pulses; queue responses for the shell model.
  initial forever begin
    int len;
    @(negedge clk);
    if (tx_re) begin
      len = (tx_rlength == 2'b11) ? 4 : ((tx_rlength == 2'b01) ? 2 : 1);
      req_q.push_back('{tx_raddr, tx_rlength, cyc});
      for (int i = 0; i < len; i++) pend.push_back('{tx_raddr + AW'(i), cyc + rsp_delay});
      req_lines += len;
    end
    if (out_rvalid) begin
      out_q.push_back(out_rdata); out_cyc.push_back(cyc); out_act.push_back(active);
      out_lines++;
    end
    if (done) done_q.push_back(cyc);
    if (req_lines - out_lines > max_outst) max_outst = req_lines - out_lines;
  end

  // Shell model: in-order responses, one line per cycle at most.
  initial forever begin
    @(negedge clk);
    rx_rvalid = 1'b0;
    if (pend.size() > 0 && cyc >= pend[0].ready && $urandom_range(99) < rx_rate) begin
      rx_rvalid = 1'b1;
      rx_rdata  = line_data(pend[0].a);
      void'(pend.pop_front());
    end
  end

  // Backpressure drivers.
  initial forever begin
    @(negedge clk);
    out_almostfull = oaf_force || (oaf_rate != 0 && $urandom_range(99) < oaf_rate);
    tx_ralmostfull = (tx_rate != 0 && $urandom_range(99) < tx_rate);
  end

  task automatic clear_logs();
    req_q.delete(); out_q.delete(); out_cyc.delete(); out_act.delete(); done_q.delete();
    req_lines = 0; out_lines = 0; max_outst = 0; stall_lines = -1; idle_cyc = 0;
  endtask

  // Start one job and wait (bounded) for completion; stall holds out_almostfull high.
  task automatic run_job(input int unsigned n, input logic [AW-1:0] a, input bit am,
                         input int unsigned stall, output bit to, output int unsigned t0);
    clear_logs();
    build_model(n, a);
    @(negedge clk);
    start = 1'b1; regs0 = n; addr = a; async = am; t0 = cyc;
    oaf_force = (stall != 0);
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (stall != 0 && cyc == t0 + stall) stall_lines = req_lines;
      if (stall != 0 && cyc >= t0 + stall) oaf_force = 1'b0;
      if (idle && done_q.size() > 0) begin
        to = 1'b0; idle_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    oaf_force = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 8;
    if (idle !== 1'b1)        begin n_errs++; $display("FAIL reset_idle: got %b want 1", idle); end
    if (active !== 1'b0)      begin n_errs++; $display("FAIL reset_active: got %b want 0", active); end
    if (done !== 1'b0)        begin n_errs++; $display("FAIL reset_done: got %b want 0", done); end
    if (tx_re !== 1'b0)       begin n_errs++; $display("FAIL reset_tx_re: got %b want 0", tx_re); end
    if (tx_raddr !== '0)      begin n_errs++; $display("FAIL reset_tx_raddr: got %0h want 0", tx_raddr); end
    if (tx_rlength !== 2'b00) begin n_errs++; $display("FAIL reset_tx_rlength: got %b want 00", tx_rlength); end
    if (out_rvalid !== 1'b0)  begin n_errs++; $display("FAIL reset_out_rvalid: got %b want 0", out_rvalid); end
    if (out_rdata !== '0)     begin n_errs++; $display("FAIL reset_out_rdata: got %0h want 0", out_rdata); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Shared shape of a normal job: requests, data, single done after last line.
  task automatic test_job(input string name, input int unsigned n, input logic [AW-1:0] a);
    bit to; int unsigned t0;
    run_job(n, a, 1'b0, 0, to, t0);
    n_checks++;
    if (to) begin n_errs++; $display("FAIL %s_timeout: idle never returned", name); end
    n_checks++;
    if (req_q.size() !== exp_addr.size()) begin
      n_errs++; $display("FAIL %s_req_count: got %0d want %0d", name, req_q.size(), exp_addr.size());
    end
    for (int i = 0; i < req_q.size() && i < exp_addr.size(); i++) begin
      n_checks++;
      if (req_q[i].a !== exp_addr[i] || req_q[i].code !== exp_code[i]) begin
        n_errs++;
        $display("FAIL %s_req%0d: got %0h/%b want %0h/%b", name, i, req_q[i].a, req_q[i].code,
                 exp_addr[i], exp_code[i]);
      end
    end
    n_checks++;
    if (out_q.size() !== exp_data.size()) begin
      n_errs++; $display("FAIL %s_out_count: got %0d want %0d", name, out_q.size(), exp_data.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_data[i]) begin
        n_errs++; $display("FAIL %s_out%0d: got %0h want %0h", name, i, out_q[i], exp_data[i]);
      end
    end
    n_checks++;
    if (done_q.size() !== 1) begin
      n_errs++; $display("FAIL %s_done_count: got %0d want 1", name, done_q.size());
    end else if (out_cyc.size() > 0) begin
      n_checks++;
      if (!(done_q[0] > out_cyc[out_cyc.size()-1])) begin
        n_errs++;
        $display("FAIL %s_done_order: done at %0d, last line at %0d", name, done_q[0],
                 out_cyc[out_cyc.size()-1]);
      end
    end
  endtask

  task automatic test_aligned();
    test_job("aligned", 8, AW'('h100));
  endtask

  task automatic test_unaligned();
    test_job("unaligned", 7, AW'('h101));
  endtask

  task automatic test_credit();
    bit to; int unsigned t0;
    run_job(32, AW'('h400), 1'b0, 100, to, t0);
    n_checks++;
    if (to) begin n_errs++; $display("FAIL credit_timeout: idle never returned"); end
    n_checks++;
    if (stall_lines !== int'(DEPTH)) begin
      n_errs++; $display("FAIL credit_stall_lines: got %0d want %0d", stall_lines, DEPTH);
    end
    n_checks++;
    if (max_outst > int'(DEPTH)) begin
      n_errs++; $display("FAIL credit_outstanding: got %0d limit %0d", max_outst, DEPTH);
    end
    n_checks++;
    if (out_q.size() !== 32) begin
      n_errs++; $display("FAIL credit_out_count: got %0d want 32", out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_data.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_data[i]) begin
        n_errs++; $display("FAIL credit_out%0d: got %0h want %0h", i, out_q[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_async();
    bit to; int unsigned t0;
    rsp_delay = 50;
    run_job(4, AW'('h800), 1'b1, 0, to, t0);
    rsp_delay = 0;
    n_checks++;
    if (to) begin n_errs++; $display("FAIL async_timeout: idle never returned"); end
    n_checks++;
    if (done_q.size() !== 1 || req_q.size() !== 1) begin
      n_errs++; $display("FAIL async_counts: done %0d req %0d want 1/1", done_q.size(), req_q.size());
    end else begin
      n_checks++;
      if (done_q[0] !== req_q[0].c) begin
        n_errs++; $display("FAIL async_done_cycle: got %0d want %0d", done_q[0], req_q[0].c);
      end
    end
    n_checks++;
    if (out_q.size() !== 4) begin
      n_errs++; $display("FAIL async_out_count: got %0d want 4", out_q.size());
    end else begin
      n_checks++;
      if (out_act[3] !== 1'b1) begin
        n_errs++; $display("FAIL async_active_last: got %b want 1", out_act[3]);
      end
      n_checks++;
      if (out_q[3] !== exp_data[3]) begin
        n_errs++; $display("FAIL async_out3: got %0h want %0h", out_q[3], exp_data[3]);
      end
    end
  endtask

  task automatic test_zero();
    bit to; int unsigned t0;
    run_job(0, AW'('h40), 1'b0, 0, to, t0);
    n_checks += 3;
    if (req_q.size() !== 0) begin n_errs++; $display("FAIL zero_tx_re: got %0d want 0", req_q.size()); end
    if (done_q.size() !== 1 || done_q[0] !== t0 + 2) begin
      n_errs++; $display("FAIL zero_done: count %0d first at t+%0d want one at t+2", done_q.size(),
                         done_q.size() > 0 ? done_q[0] - t0 : 0);
    end
    if (to || idle_cyc !== t0 + 3) begin
      n_errs++; $display("FAIL zero_idle: got t+%0d want t+3", idle_cyc - t0);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    @(negedge clk);
    start = 1'b1; regs0 = 64; addr = AW'('h200); async = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rsp_delay = 30;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (idle !== 1'b1)       begin n_errs++; $display("FAIL midreset_idle: got %b want 1", idle); end
    if (tx_re !== 1'b0)      begin n_errs++; $display("FAIL midreset_tx_re: got %b want 0", tx_re); end
    if (out_rvalid !== 1'b0) begin n_errs++; $display("FAIL midreset_out_rvalid: got %b want 0", out_rvalid); end
    if (active !== 1'b0)     begin n_errs++; $display("FAIL midreset_active: got %b want 0", active); end
    reset = 1'b0;
    pend.delete();
    rsp_delay = 0;
    repeat (3) @(negedge clk);
    pend.delete();
    test_job("post_reset", 4, AW'('h300));
  endtask

  task automatic test_back_to_back();
    bit to; int unsigned t0;
    for (int j = 0; j < 2; j++) begin
      run_job(8, AW'('h1000 + j * 'h40), 1'b0, 0, to, t0);
      n_checks++;
      if (to || out_q.size() !== 8) begin
        n_errs++; $display("FAIL b2b%0d_count: got %0d lines want 8", j, out_q.size());
      end else begin
        n_checks++;
        if (out_cyc[7] - out_cyc[0] !== 7) begin
          n_errs++; $display("FAIL b2b%0d_throughput: span %0d want 7", j, out_cyc[7] - out_cyc[0]);
        end
        n_checks++;
        if (out_q[7] !== exp_data[7] || out_q[0] !== exp_data[0]) begin
          n_errs++; $display("FAIL b2b%0d_data: got %0h..%0h want %0h..%0h", j, out_q[0], out_q[7],
                             exp_data[0], exp_data[7]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit to; int unsigned t0, n; bit am; logic [AW-1:0] a; int bad;
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(40, 1);
      a = AW'($urandom);
      am = 1'($urandom_range(1));
      oaf_rate = $urandom_range(50); tx_rate = $urandom_range(50);
      rx_rate = $urandom_range(100, 50); rsp_delay = $urandom_range(20);
      run_job(n, a, am, 0, to, t0);
      n_checks++;
      if (to) begin n_errs++; $display("FAIL rnd%0d_timeout: idle never returned", j); end
      n_checks++;
      if (req_q.size() !== exp_addr.size() || out_q.size() !== exp_data.size()) begin
        n_errs++; $display("FAIL rnd%0d_counts: req %0d/%0d out %0d/%0d", j, req_q.size(),
                           exp_addr.size(), out_q.size(), exp_data.size());
      end
      bad = 0;
      for (int i = 0; i < req_q.size() && i < exp_addr.size(); i++)
        if (req_q[i].a !== exp_addr[i] || req_q[i].code !== exp_code[i]) bad++;
      for (int i = 0; i < out_q.size() && i < exp_data.size(); i++)
        if (out_q[i] !== exp_data[i]) bad++;
      n_checks++;
      if (bad !== 0) begin n_errs++; $display("FAIL rnd%0d_content: %0d wrong items want 0", j, bad); end
      n_checks++;
      if (done_q.size() !== 1) begin
        n_errs++; $display("FAIL rnd%0d_done_count: got %0d want 1", j, done_q.size());
      end
      n_checks++;
      if (max_outst > int'(DEPTH)) begin
        n_errs++; $display("FAIL rnd%0d_outstanding: got %0d limit %0d", j, max_outst, DEPTH);
      end
    end
    oaf_rate = 0; tx_rate = 0; rx_rate = 100; rsp_delay = 0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_credit();
    test_async();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
